// File: rtl/async_fifo_read_ctrl_if.sv
// Consumer-side handshake of the async FIFO read channel: pop request, head data, status flags.
interface async_fifo_read_ctrl_if #(
    parameter int FIFO_DATA_WIDTH = 32
);
    logic                       read_fifo_pop;
    logic [FIFO_DATA_WIDTH-1:0] read_data;
    logic                       read_fifo_empty;
    logic                       read_fifo_underflow;

    modport master (
        output read_fifo_pop,
        input  read_data,
        input  read_fifo_empty,
        input  read_fifo_underflow
    );

    modport slave (
        input  read_fifo_pop,
        output read_data,
        output read_fifo_empty,
        output read_fifo_underflow
    );
endinterface

// File: rtl/async_fifo_read_ctrl.sv
// Read-domain controller of the async FIFO: read pointer, write-pointer sync, empty/underflow, registered data.
// Optional occupancy output read_fifo_level is enabled by defining ASYNC_FIFO_READ_LEVEL_EN.
module async_fifo_read_ctrl #(
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                       read_clk,
    input  logic                       read_reset_n,
    async_fifo_read_ctrl_if.slave      rd,
    input  logic [FIFO_ADDR_WIDTH:0]   wptr_gray,
    output logic [FIFO_ADDR_WIDTH:0]   rptr_gray,
    output logic [FIFO_ADDR_WIDTH-1:0] mem_raddr,
    input  logic [FIFO_DATA_WIDTH-1:0] mem_rdata
`ifdef ASYNC_FIFO_READ_LEVEL_EN
    ,
    output logic [FIFO_ADDR_WIDTH:0]   read_fifo_level
`endif
);

    localparam int PW = FIFO_ADDR_WIDTH + 1;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

`ifdef ASYNC_FIFO_READ_LEVEL_EN
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
`endif

    logic [PW-1:0]              rbin_p0;
    logic [PW-1:0]              rgray_p0;
    logic [PW-1:0]              wsync_p  [SYNC_STAGES];
    logic                       empty_p0;
    logic                       underflow_p0;
    logic [FIFO_DATA_WIDTH-1:0] data_p0;

    logic                       pop_ok;
    logic [PW-1:0]              rbin_next;
    logic [PW-1:0]              rgray_next;
    logic [PW-1:0]              wsync;

    assign pop_ok     = rd.read_fifo_pop & ~empty_p0;
    assign rbin_next  = rbin_p0 + {{(PW-1){1'b0}}, pop_ok};
    assign rgray_next = bin2gray(rbin_next);
    assign wsync      = wsync_p[SYNC_STAGES-1];

`ifdef ASYNC_FIFO_READ_LEVEL_EN
    logic [PW-1:0] level_p0;
    logic [PW-1:0] wbin;

    assign wbin            = gray2bin(wsync);
    assign read_fifo_level = level_p0;
`endif

    // Flag and level compare against the post-pop pointer so full-rate pops never overrun.
    always_ff @(posedge read_clk) begin
        if (!read_reset_n) begin
            rbin_p0      <= '0;
            rgray_p0     <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wsync_p[i] <= '0;
            end
            empty_p0     <= 1'b1;
            underflow_p0 <= 1'b0;
            data_p0      <= '0;
`ifdef ASYNC_FIFO_READ_LEVEL_EN
            level_p0     <= '0;
`endif
        end else begin
            wsync_p[0] <= wptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wsync_p[i] <= wsync_p[i-1];
            end
            rbin_p0      <= rbin_next;
            rgray_p0     <= rgray_next;
            empty_p0     <= (rgray_next == wsync);
            underflow_p0 <= rd.read_fifo_pop & empty_p0;
            if (pop_ok) begin
                data_p0 <= mem_rdata;
            end
`ifdef ASYNC_FIFO_READ_LEVEL_EN
            level_p0     <= wbin - rbin_next;
`endif
        end
    end

    assign rd.read_data           = data_p0;
    assign rd.read_fifo_empty     = empty_p0;
    assign rd.read_fifo_underflow = underflow_p0;
    assign rptr_gray              = rgray_p0;
    assign mem_raddr              = rbin_p0[FIFO_ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_async_fifo_read_ctrl.sv
// Bench for async_fifo_read_ctrl: models the write side and storage, scoreboards popped data.
module tb_async_fifo_read_ctrl;

    logic        clk = 1'b0;
    logic        read_reset_n;
    logic [4:0]  wptr_gray;
    logic [4:0]  rptr_gray;
    logic [3:0]  mem_raddr;
    logic [31:0] mem_rdata;
    logic [31:0] mem [16];
`ifdef ASYNC_FIFO_READ_LEVEL_EN
    logic [4:0]  read_fifo_level;
`endif

    logic [4:0]  wbin;
    logic [31:0] sb [$];
    int          checks = 0;
    int          errors = 0;

    async_fifo_read_ctrl_if #(.FIFO_DATA_WIDTH(32)) rd_if ();

    async_fifo_read_ctrl #(
        .FIFO_DATA_WIDTH (32),
        .FIFO_ADDR_WIDTH (4),
        .SYNC_STAGES     (2)
    ) dut (
        .read_clk        (clk),
        .read_reset_n    (read_reset_n),
        .rd              (rd_if),
        .wptr_gray       (wptr_gray),
        .rptr_gray       (rptr_gray),
        .mem_raddr       (mem_raddr),
        .mem_rdata       (mem_rdata)
`ifdef ASYNC_FIFO_READ_LEVEL_EN
        ,
        .read_fifo_level (read_fifo_level)
`endif
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_raddr];

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [31:0] d);
        mem[wbin[3:0]] = d;
        sb.push_back(d);
        wbin = wbin + 5'd1;
        wptr_gray = to_gray(wbin);
    endtask

    task automatic do_reset();
        read_reset_n = 1'b0;
        rd_if.read_fifo_pop = 1'b0;
        wbin = '0;
        wptr_gray = '0;
        sb.delete();
        tick();
        read_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        read_reset_n = 1'b0;
        rd_if.read_fifo_pop = 1'b1;
        wptr_gray = 5'd5;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (rd_if.read_fifo_empty !== 1'b1 || rd_if.read_data !== 32'h0 ||
                rptr_gray !== 5'h0 || rd_if.read_fifo_underflow !== 1'b0) begin
                errors++;
                $display("FAIL reset: empty=%b data=%h rptr=%h underflow=%b, want 1/0/0/0",
                         rd_if.read_fifo_empty, rd_if.read_data, rptr_gray, rd_if.read_fifo_underflow);
            end
        end
        do_reset();
    endtask

    task automatic test_single();
        write_entry(32'hA5A5_0001);
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if (rd_if.read_fifo_empty !== (e < 3)) begin
                errors++;
                $display("FAIL single_empty_edge%0d: empty=%b want %b", e, rd_if.read_fifo_empty, e < 3);
            end
        end
        checks++;
        if (mem_raddr !== 4'd0) begin
            errors++;
            $display("FAIL single_raddr: got %0d want 0", mem_raddr);
        end
        rd_if.read_fifo_pop = 1'b1;
        tick();
        rd_if.read_fifo_pop = 1'b0;
        checks++;
        if (rd_if.read_data !== sb.pop_front() || rptr_gray !== 5'd1 ||
            rd_if.read_fifo_empty !== 1'b1 || mem_raddr !== 4'd1) begin
            errors++;
            $display("FAIL single_pop: data=%h rptr=%h empty=%b raddr=%0d want a5a50001/01/1/1",
                     rd_if.read_data, rptr_gray, rd_if.read_fifo_empty, mem_raddr);
        end
    endtask

    task automatic test_underflow();
        rd_if.read_fifo_pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) rd_if.read_fifo_pop = 1'b0;
            tick();
            checks++;
            if (rd_if.read_fifo_underflow !== (i < 2) || rptr_gray !== 5'd1 ||
                rd_if.read_data !== 32'hA5A5_0001) begin
                errors++;
                $display("FAIL underflow_%0d: uf=%b rptr=%h data=%h want %b/01/a5a50001",
                         i, rd_if.read_fifo_underflow, rptr_gray, rd_if.read_data, i < 2);
            end
        end
    endtask

    task automatic test_wrap();
        int  pops = 0;
        int  written = 0;
        logic pend = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 200 && pops < 20; cyc++) begin
            if (pend) begin
                pops++;
                checks++;
                if (sb.size() == 0 || rd_if.read_data !== sb[0] || rptr_gray !== to_gray(5'(pops))) begin
                    errors++;
                    $display("FAIL wrap_pop%0d: data=%h rptr=%h want %h/%h", pops, rd_if.read_data,
                             rptr_gray, (sb.size() != 0) ? sb[0] : 32'hx, to_gray(5'(pops)));
                end
                if (sb.size() != 0) void'(sb.pop_front());
                if (pops == 16) begin
                    checks++;
                    if (rptr_gray !== 5'b11000) begin
                        errors++;
                        $display("FAIL wrap_rptr16: got %b want 11000", rptr_gray);
                    end
                end
            end
            if (written < 20) begin
                write_entry(32'hC0DE_0000 + 32'(written));
                written++;
            end
            pend = !rd_if.read_fifo_empty && pops < 20;
            if (pend) begin
                checks++;
                if (mem_raddr !== 4'(pops % 16)) begin
                    errors++;
                    $display("FAIL wrap_raddr: got %0d want %0d", mem_raddr, pops % 16);
                end
            end
            rd_if.read_fifo_pop = pend;
            tick();
        end
        rd_if.read_fifo_pop = 1'b0;
        checks++;
        if (pops != 20) begin
            errors++;
            $display("FAIL wrap_count: popped %0d want 20", pops);
        end
        tick(); tick(); tick();
        checks++;
        if (rd_if.read_fifo_empty !== 1'b1 || rd_if.read_fifo_underflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_drained: empty=%b uf=%b want 1/0", rd_if.read_fifo_empty, rd_if.read_fifo_underflow);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 10; i++) write_entry($urandom);
        tick(); tick(); tick();
        rd_if.read_fifo_pop = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (rd_if.read_data !== sb[0] || rptr_gray !== to_gray(5'(i + 1)) || rd_if.read_fifo_empty !== 1'b0) begin
                errors++;
                $display("FAIL mid_pop%0d: data=%h rptr=%h empty=%b want %h/%h/0",
                         i, rd_if.read_data, rptr_gray, rd_if.read_fifo_empty, sb[0], to_gray(5'(i + 1)));
            end
            void'(sb.pop_front());
        end
        rd_if.read_fifo_pop = 1'b0;
        read_reset_n = 1'b0;
        tick();
        checks++;
        if (rptr_gray !== 5'd0 || rd_if.read_fifo_empty !== 1'b1 || rd_if.read_data !== 32'h0 || mem_raddr !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: rptr=%h empty=%b data=%h raddr=%0d want 0/1/0/0",
                     rptr_gray, rd_if.read_fifo_empty, rd_if.read_data, mem_raddr);
        end
        do_reset();
    endtask

`ifdef ASYNC_FIFO_READ_LEVEL_EN
    task automatic test_level();
        do_reset();
        for (int i = 0; i < 16; i++) write_entry(32'h1EE1_0000 + 32'(i));
        tick(); tick(); tick();
        checks++;
        if (read_fifo_level !== 5'd16 || rd_if.read_fifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL level_full: level=%0d empty=%b want 16/0", read_fifo_level, rd_if.read_fifo_empty);
        end
        rd_if.read_fifo_pop = 1'b1;
        tick();
        rd_if.read_fifo_pop = 1'b0;
        checks++;
        if (read_fifo_level !== 5'd15 || rd_if.read_data !== sb[0]) begin
            errors++;
            $display("FAIL level_pop: level=%0d data=%h want 15/%h", read_fifo_level, rd_if.read_data, sb[0]);
        end
        void'(sb.pop_front());
    endtask
`endif

    initial begin
        read_reset_n = 1'b1;
        rd_if.read_fifo_pop = 1'b0;
        wptr_gray = '0;
        wbin = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        #2;
        test_reset();
        test_single();
        test_underflow();
        test_wrap();
        test_reset_midstream();
`ifdef ASYNC_FIFO_READ_LEVEL_EN
        test_level();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/async_fifo_read_ctrl.md
# async_fifo_read_ctrl

Read-side controller of the asynchronous FIFO, the counterpart of the write channel (push/data/full). It lives entirely in the read clock domain. It owns the read pointer, synchronizes the Gray-coded write pointer from the write domain, generates `read_fifo_empty`, addresses the dual-port storage and registers popped data onto `read_data`. It returns its own Gray read pointer to the write side for full generation.

## Interface
Parameters:
- FIFO_DATA_WIDTH, 32, width of each entry / `read_data`
- FIFO_ADDR_WIDTH, 4, log2 of FIFO depth (default depth 16); pointers are FIFO_ADDR_WIDTH+1 bits
- SYNC_STAGES, 2, flop stages on the incoming write pointer (legal ≥2)

Ports:
- read_clk  in  1  read-domain clock
- read_reset_n  in  1  reset, synchronous to read_clk, active-low
- read_fifo_pop  in  1  consumer request to remove the head entry
- read_data  out  FIFO_DATA_WIDTH  registered head entry from the last accepted pop
- read_fifo_empty  out  1  registered; no entry available to pop
- read_fifo_underflow  out  1  one-cycle pulse: pop requested while empty
- wptr_gray  in  FIFO_ADDR_WIDTH+1  Gray write pointer, asynchronous (write domain)
- rptr_gray  out  FIFO_ADDR_WIDTH+1  registered Gray read pointer, to write-domain synchronizer
- mem_raddr  out  FIFO_ADDR_WIDTH  storage read address
- mem_rdata  in  FIFO_DATA_WIDTH  storage data at mem_raddr, combinational read
- read_fifo_level  out  FIFO_ADDR_WIDTH+1  occupancy, only with ASYNC_FIFO_READ_LEVEL_EN

## Operation
- State: binary read pointer `rbin`, Gray `rgray`, SYNC_STAGES-deep sync chain on wptr_gray, `read_fifo_empty`, `read_data`, underflow flag.
- Reset (read_reset_n low at a read_clk edge): rbin=0, rgray=0, all sync flops=0, read_fifo_empty=1, read_data=0, read_fifo_underflow=0, read_fifo_level=0. Pop is ignored in the same cycle.
- Accept: `pop_ok = read_fifo_pop & ~read_fifo_empty`. On pop_ok, read_data <= mem_rdata, and rbin increments by 1 modulo 2^(FIFO_ADDR_WIDTH+1). rgray <= rbin_next ^ (rbin_next >> 1).
- mem_raddr = rbin[FIFO_ADDR_WIDTH-1:0]. Wrap from depth-1 to 0 occurs naturally; the MSB toggles on each wrap.
- Pop while empty: pointers and read_data are unchanged. read_fifo_underflow = 1 for the next cycle only.
- No pop: read_data holds its value indefinitely.
- Empty: read_fifo_empty <= (rgray_next == wsync), where wsync is the last sync stage. It is conservative: it may stay asserted after a write, but it never deasserts falsely.
- rptr_gray = rgray register. Exactly one bit changes per increment.
- Simultaneous pop of the last entry and a new write arriving: empty asserts first and deasserts once the new pointer is synchronized. No data is lost.

## Timing
- Pop accepted at edge N → read_data valid after edge N, so it is visible in cycle N+1.
- The empty flag updates at the same edge as the pop, so back-to-back pops at full rate are legal while not empty.
- A wptr_gray change that is stable before edge E reaches wsync at edge E+SYNC_STAGES-1. read_fifo_empty falls at edge E+SYNC_STAGES (3rd edge for default).
- rptr_gray changes at the same edge as the accepted pop.
- No combinational path from read_fifo_pop to any output except mem_raddr (registered source only).

## Configuration
- ASYNC_FIFO_READ_LEVEL_EN defined: port read_fifo_level is present.
  - Gray-to-binary of wsync gives wbin.
  - read_fifo_level <= (wbin − rbin_next) mod 2^(FIFO_ADDR_WIDTH+1), range 0..2^FIFO_ADDR_WIDTH.
  - It is registered alongside empty and equals 0 exactly when read_fifo_empty=1.
- Not defined: the port, the converter and the register are absent. All other behaviour is identical.

## Test plan
- Reset: hold read_reset_n=0 for 2 edges with pop=1 and wptr_gray=5 → empty=1, read_data=0, rptr_gray=0, underflow=0 throughout.
- Single entry: wptr_gray 0→1, mem_rdata=0xA5A5_0001 → empty falls on the 3rd edge. Pop one cycle → read_data=0xA5A5_0001, rptr_gray=1, empty=1 at the same edge.
- Underflow: pop=1 while empty for 2 cycles → underflow pulses each following cycle, rptr_gray and read_data unchanged.
- Wrap: depth 16, write 20 entries and pop 20 continuously → mem_raddr sequence 0..15,0..3. rptr_gray after 16 pops = 5'b11000. Data order is preserved.
- Reset mid-stream: after 7 pops, read_reset_n=0 for one edge → rptr_gray=0, empty=1, read_data=0 on the next cycle.
- Level (with ASYNC_FIFO_READ_LEVEL_EN): write 16 entries (Gray of 16) with no pops → level=16 after sync. 1 pop → 15.
